// File: rtl/png_pkg.sv
// Shared types for the PNG pixel sink: pixel format, sink FSM states and write beats.
package png_pkg;

  localparam int unsigned PIX_BYTES_LOG2 = 2;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] a;
  } rgba_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2
  } sink_state_e;

  typedef struct packed {
    logic [31:0] addr;
    rgba_t       data;
    logic        last;
  } beat_t;

  // Pixel index to byte offset; RGBA pixels are four bytes, so a shift suffices.
  function automatic logic [31:0] byte_offset(input logic [31:0] pix_idx);
    return pix_idx << PIX_BYTES_LOG2;
  endfunction

endpackage

// File: rtl/png_sink_fifo.sv
// Synchronous beat FIFO with registered full/empty flags; head is read straight from storage.
module png_sink_fifo
  import png_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  beat_t push_beat,
  input  logic  pop,
  output beat_t head,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);

  beat_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      empty <= (count_next == (AW+1)'(0));
    end
  end

  // Storage needs no reset: entries are only visible once written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_beat;
  end

endmodule

// File: rtl/png_pixel_sink.sv
// Receives an sof/eol framed RGBA stream, checks frame geometry and emits addressed write beats.
module png_pixel_sink
  import png_pkg::*;
#(
  parameter int          IMG_WIDTH  = 240,
  parameter int          IMG_HEIGHT = 240,
  parameter int          PIX_W      = 32,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_data,
  input  logic             s_sof,
  input  logic             s_eol,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_addr,
  output logic [PIX_W-1:0] m_data,
  output logic             m_last,
  output logic             done,
  output logic             err_sof,
  output logic             err_eol,
  output logic [15:0]      frame_cnt
);

  localparam logic [15:0] X_LAST   = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] Y_LAST   = 16'(IMG_HEIGHT - 1);
  localparam logic [31:0] ROW_STEP = 32'(IMG_WIDTH);

  sink_state_e state, state_next;
  logic [15:0] x, y, x_next, y_next, px, py;
  logic [31:0] row_base, row_base_next, pbase;
  logic [15:0] frame_cnt_next;
  logic        done_next, err_sof_next, err_eol_next;
  logic        accept, start, store, at_eol_pos, is_last, wrap;
  logic        fifo_full, fifo_empty, last_pop;
  beat_t       push_beat, head;

  assign s_ready    = ~reset & ((state == IDLE) | ((state == RECV) & ~fifo_full));
  assign accept     = s_valid & s_ready;
  assign start      = accept & s_sof;
  // A pixel carrying sof always restarts at (0,0), even in the middle of a frame.
  assign px         = start ? 16'd0 : x;
  assign py         = start ? 16'd0 : y;
  assign pbase      = start ? 32'd0 : row_base;
  assign at_eol_pos = (px == X_LAST);
  assign is_last    = at_eol_pos & (py == Y_LAST);
  assign wrap       = at_eol_pos | s_eol;
  assign last_pop   = m_ready & ~fifo_empty & head.last;

  always_comb begin
    state_next     = state;
    x_next         = x;
    y_next         = y;
    row_base_next  = row_base;
    done_next      = done;
    err_sof_next   = err_sof;
    err_eol_next   = err_eol;
    frame_cnt_next = frame_cnt;
    store          = 1'b0;
    push_beat      = '0;
    case (state)
      IDLE: begin
        if (start) begin
          store     = 1'b1;
          done_next = 1'b0;
        end else begin
          store = 1'b0;
        end
      end
      RECV: begin
        if (accept) begin
          store        = 1'b1;
          err_sof_next = err_sof | s_sof;
        end else begin
          store = 1'b0;
        end
      end
      DRAIN: begin
        if (last_pop) begin
          done_next      = 1'b1;
          frame_cnt_next = frame_cnt + 16'd1;
          state_next     = IDLE;
        end else begin
          state_next = DRAIN;
        end
      end
      default: state_next = IDLE;
    endcase
    // Misplaced eol is flagged but the pixel is still written and the line wraps anyway.
    if (store) begin
      push_beat.addr = BASE_ADDR + byte_offset(pbase + 32'(px));
      push_beat.data = rgba_t'(s_data);
      push_beat.last = is_last;
      err_eol_next   = err_eol | (s_eol ^ at_eol_pos);
      x_next         = wrap ? 16'd0 : px + 16'd1;
      y_next         = wrap ? py + 16'd1 : py;
      row_base_next  = wrap ? pbase + ROW_STEP : pbase;
      state_next     = is_last ? DRAIN : RECV;
    end else begin
      push_beat = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      x         <= 16'd0;
      y         <= 16'd0;
      row_base  <= 32'd0;
      done      <= 1'b0;
      err_sof   <= 1'b0;
      err_eol   <= 1'b0;
      frame_cnt <= 16'd0;
    end else begin
      state     <= state_next;
      x         <= x_next;
      y         <= y_next;
      row_base  <= row_base_next;
      done      <= done_next;
      err_sof   <= err_sof_next;
      err_eol   <= err_eol_next;
      frame_cnt <= frame_cnt_next;
    end
  end

  png_sink_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (store),
    .push_beat(push_beat),
    .pop      (m_ready),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign m_valid = ~fifo_empty;
  assign m_addr  = fifo_empty ? 32'd0 : head.addr;
  assign m_data  = fifo_empty ? '0 : PIX_W'(head.data);
  assign m_last  = ~fifo_empty & head.last;

endmodule
